// File: rtl/io_in_pad_filt.sv
// Input pad: per-channel synchroniser, optional debounce filter, fan-out copies and edge pulses.
// Define IO_IN_PAD_FILTER_EN to include the debounce counter; without it the synchronised level passes straight through.
module io_in_pad_filt #(
  parameter int WIDTH       = 1,
  parameter int FANOUT      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int INIT        = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          top_pin,
  output logic [FANOUT*WIDTH-1:0]   pin,
  output logic [WIDTH-1:0]          rise,
  output logic [WIDTH-1:0]          fall
);

  localparam logic INIT_BIT = (INIT != 0);

  if (WIDTH < 1 || FANOUT < 1 || SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_err
    $error("io_in_pad_filt: illegal parameters (need WIDTH>=1, FANOUT>=1, SYNC_STAGES>=2, FILTER_LEN>=1)");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_out;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {WIDTH{INIT_BIT}};
      end
    end else begin
      sync_q[0] <= top_pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_out = sync_q[SYNC_STAGES-1];

`ifdef IO_IN_PAD_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // Any cycle where the synced input agrees with the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt <= {WIDTH{INIT_BIT}};
      for (int c = 0; c < WIDTH; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        if (s_out[c] == filt[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CNT_LAST) begin
          filt[c] <= s_out[c];
          cnt[c]  <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt <= {WIDTH{INIT_BIT}};
    end else begin
      filt <= s_out;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_d <= {WIDTH{INIT_BIT}};
    end else begin
      filt_d <= filt;
    end
  end

  assign pin  = {FANOUT{filt}};
  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;

endmodule
